// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared LC-3b line/word types, arbiter state and requester enums.
package cache_mem_arbiter_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_cache_line;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} lc3b_arb_state;
  typedef enum logic {ARB_ICACHE, ARB_DCACHE} lc3b_arb_req;
  localparam lc3b_word LINE_ALIGN_MASK = 16'hfff0;
endpackage

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one line memory port between I-cache and D-cache misses.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int WAIT_W = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_read,
  input  lc3b_word       i_address,
  output lc3b_cache_line i_rdata,
  output logic           i_resp,
  input  logic           d_read,
  input  logic           d_write,
  input  lc3b_word       d_address,
  input  lc3b_cache_line d_wdata,
  output lc3b_cache_line d_rdata,
  output logic           d_resp,
  output logic           mem_read,
  output logic           mem_write,
  output lc3b_word       mem_address,
  output lc3b_cache_line mem_wdata,
  input  lc3b_cache_line mem_rdata,
  input  logic           mem_resp,
  output logic           busy,
  output logic           timeout_err
);
  lc3b_arb_state state, state_nxt;
  lc3b_arb_req last_grant;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic d_req, grant_d, grant_i, serving;
  assign d_req = d_read | d_write;
  // D wins unless I is also pending and D was served last
  assign grant_d = state == IDLE && d_req && (!i_read || last_grant == ARB_ICACHE);
  assign grant_i = state == IDLE && i_read && !grant_d;
  assign serving = state == SERVE_I || state == SERVE_D;
  assign i_resp = state == SERVE_I && mem_resp;
  assign d_resp = state == SERVE_D && mem_resp;
  assign busy = state != IDLE;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign wait_nxt = &wait_cnt ? wait_cnt : wait_cnt + 1'b1;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE;
      SERVE_I,
      SERVE_D: state_nxt = mem_resp ? RELEASE : state;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= ARB_ICACHE;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_wdata <= '0;
      wait_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_d || grant_i) begin
        mem_address <= (grant_d ? d_address : i_address) & LINE_ALIGN_MASK;
        mem_wdata <= grant_d ? d_wdata : '0;
        mem_read <= grant_i || !d_write;
        mem_write <= grant_d && d_write;
        wait_cnt <= '0;
      end else if (serving && mem_resp) begin
        mem_read <= 1'b0;
        mem_write <= 1'b0;
        last_grant <= state == SERVE_D ? ARB_DCACHE : ARB_ICACHE;
      end else if (serving) begin
        wait_cnt <= wait_nxt;
        if (wait_nxt == WAIT_W'(MAX_WAIT)) timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: table-driven cycle vectors plus watchdog and mid-transaction reset sequences.
module tb_cache_mem_arbiter;
  logic clk = 0, rst_n = 0;
  logic i_read = 0, d_read = 0, d_write = 0, mem_resp = 0;
  logic [15:0] i_address = 16'h1234, d_address = 16'h0000;
  logic [127:0] d_wdata = 128'hffff_ffff_ffff_ffff_0000_0000_0000_0000;
  logic [127:0] mem_rdata = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
  logic [127:0] i_rdata, d_rdata, mem_wdata;
  logic i_resp, d_resp, mem_read, mem_write, busy, timeout_err;
  logic [15:0] mem_address;
  int checks = 0, errors = 0;

  localparam logic [127:0] RLINE = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
  localparam logic [127:0] WLINE = 128'hffff_ffff_ffff_ffff_0000_0000_0000_0000;

  cache_mem_arbiter #(.WAIT_W(8), .MAX_WAIT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rn, ir, dr, dw, mr;
    logic [15:0] da;
    logic e_mr, e_mw, e_ir, e_dr, e_busy;
    logic [15:0] e_addr;
    logic ca;
  } vec_t;

  vec_t v[24];

  initial begin
    //         rn ir dr dw mr  da        mr mw ir dr by addr      ca
    v[0]  = '{1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0};
    v[1]  = '{1, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 16'h1230, 1};
    v[2]  = '{1, 1, 0, 0, 1, 16'h0000, 1, 0, 1, 0, 1, 16'h1230, 1};
    v[3]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 0};
    v[4]  = '{1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0};
    v[5]  = '{1, 0, 0, 1, 0, 16'habcd, 0, 0, 0, 0, 0, 16'h0000, 0};
    v[6]  = '{1, 0, 0, 1, 0, 16'habcd, 0, 1, 0, 0, 1, 16'habc0, 1};
    v[7]  = '{1, 0, 0, 1, 1, 16'habcd, 0, 1, 0, 1, 1, 16'habc0, 1};
    v[8]  = '{1, 0, 0, 0, 0, 16'habcd, 0, 0, 0, 0, 1, 16'h0000, 0};
    v[9]  = '{1, 0, 0, 0, 0, 16'habcd, 0, 0, 0, 0, 0, 16'h0000, 0};
    v[10] = '{0, 1, 1, 0, 0, 16'h5678, 0, 0, 0, 0, 0, 16'h0000, 0};
    v[11] = '{1, 1, 1, 0, 0, 16'h5678, 0, 0, 0, 0, 0, 16'h0000, 1};
    v[12] = '{1, 1, 1, 0, 0, 16'h5678, 1, 0, 0, 0, 1, 16'h5670, 1};
    v[13] = '{1, 1, 1, 0, 1, 16'h5678, 1, 0, 0, 1, 1, 16'h5670, 1};
    v[14] = '{1, 1, 1, 0, 0, 16'h5678, 0, 0, 0, 0, 1, 16'h0000, 0};
    v[15] = '{1, 1, 1, 0, 0, 16'h5678, 0, 0, 0, 0, 0, 16'h0000, 0};
    v[16] = '{1, 1, 1, 0, 0, 16'h5678, 1, 0, 0, 0, 1, 16'h1230, 1};
    v[17] = '{1, 1, 1, 0, 1, 16'h5678, 1, 0, 1, 0, 1, 16'h1230, 1};
    v[18] = '{1, 1, 1, 0, 0, 16'h5678, 0, 0, 0, 0, 1, 16'h0000, 0};
    v[19] = '{1, 1, 1, 0, 0, 16'h5678, 0, 0, 0, 0, 0, 16'h0000, 0};
    v[20] = '{1, 1, 1, 0, 0, 16'h5678, 1, 0, 0, 0, 1, 16'h5670, 1};
    v[21] = '{1, 0, 1, 0, 1, 16'h5678, 1, 0, 0, 1, 1, 16'h5670, 1};
    v[22] = '{1, 0, 0, 0, 0, 16'h5678, 0, 0, 0, 0, 1, 16'h0000, 0};
    v[23] = '{1, 0, 0, 0, 0, 16'h5678, 0, 0, 0, 0, 0, 16'h0000, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_n = 1;

    for (int k = 0; k < 24; k++) begin
      rst_n = v[k].rn; i_read = v[k].ir; d_read = v[k].dr; d_write = v[k].dw;
      mem_resp = v[k].mr; d_address = v[k].da;
      #2;
      chk($sformatf("v%0d_mem_read", k), mem_read, v[k].e_mr);
      chk($sformatf("v%0d_mem_write", k), mem_write, v[k].e_mw);
      chk($sformatf("v%0d_i_resp", k), i_resp, v[k].e_ir);
      chk($sformatf("v%0d_d_resp", k), d_resp, v[k].e_dr);
      chk($sformatf("v%0d_busy", k), busy, v[k].e_busy);
      if (v[k].ca) chk($sformatf("v%0d_mem_address", k), mem_address, v[k].e_addr);
      if (v[k].e_ir) chk($sformatf("v%0d_i_rdata", k), i_rdata, RLINE);
      if (v[k].e_dr) chk($sformatf("v%0d_d_rdata", k), d_rdata, RLINE);
      if (v[k].e_mw) chk($sformatf("v%0d_mem_wdata", k), mem_wdata, WLINE);
      @(posedge clk);
      #1;
    end

    // Watchdog: withhold mem_resp on an I-cache read
    i_read = 1; d_read = 0; d_write = 0; mem_resp = 0;
    @(posedge clk); #1;
    begin
      int n;
      n = 0;
      while (!timeout_err && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      chk("wd_cycles", n, 255);
    end
    chk("wd_flag", timeout_err, 1);
    chk("wd_mem_read_held", mem_read, 1);
    mem_resp = 1;
    #1;
    chk("wd_late_i_resp", i_resp, 1);
    @(posedge clk); #1;
    mem_resp = 0; i_read = 0;
    chk("wd_mem_read_drop", mem_read, 0);
    chk("wd_sticky", timeout_err, 1);
    @(posedge clk); #1;
    chk("wd_idle", busy, 0);

    // Reset in the middle of a D-cache write-back
    d_write = 1; d_address = 16'habcd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mrst_pre_write", mem_write, 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mrst_mem_write", mem_write, 0);
    chk("mrst_mem_read", mem_read, 0);
    chk("mrst_mem_address", mem_address, 0);
    chk("mrst_mem_wdata", mem_wdata, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_timeout", timeout_err, 0);
    rst_n = 1; d_write = 0; mem_resp = 1;
    #1;
    chk("mrst_i_resp", i_resp, 0);
    chk("mrst_d_resp", d_resp, 0);
    @(posedge clk); #1;
    mem_resp = 0;
    chk("mrst_stay_idle", busy, 0);
    chk("mrst_no_cmd", mem_read | mem_write, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single downstream cache-line memory port (L2 cache / physical memory) between the L1 instruction-cache miss path and the L1 data-cache miss path.
- Grants one requester at a time and forwards its line read or line write downstream.
- Steers the response back to the granted requester.
- Alternates grants round-robin when both requesters contend, and flags a stalled downstream with a watchdog.

Parameters:
- WAIT_W, 8, watchdog counter width.
- MAX_WAIT, 255, cycles spent waiting for mem_resp before timeout_err sets; must satisfy MAX_WAIT < 2^WAIT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  16  I-cache request address (lc3b_word).
- i_rdata  out  128  line returned to I-cache (lc3b_cache_line).
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line write-back request; held until d_resp.
- d_address  in  16  D-cache request address.
- d_wdata  in  128  D-cache write-back line.
- d_rdata  out  128  line returned to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  downstream line read.
- mem_write  out  1  downstream line write.
- mem_address  out  16  downstream address, line aligned.
- mem_wdata  out  128  downstream write line.
- mem_rdata  in  128  downstream read line.
- mem_resp  in  1  downstream completion.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset:
  - Applied on any clk edge with rst_n=0, including mid-transaction.
  - Forces state=IDLE and last_grant=ICACHE, so the D-cache wins the first tie.
  - Forces mem_read=mem_write=0, mem_address=0, mem_wdata=0, i_resp=d_resp=0, busy=0, timeout_err=0, and wait counter=0.
  - A mem_resp arriving during or after reset while in IDLE is ignored.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE:
  - A pending request is i_read, or d_read|d_write.
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant.
  - On grant, register mem_address, mem_wdata and the mem_read/mem_write commands at that edge. They are visible the cycle after the request is first seen.
  - mem_address = requester address with bits [3:0] forced to 0 (lc3b_c_offset width).
  - mem_address, mem_wdata, mem_read and mem_write are held stable until the response.
- SERVE_I: mem_read=1, mem_write=0.
- SERVE_D:
  - d_write=1 gives mem_write=1, mem_read=0. d_write wins if d_read and d_write are both high.
  - Otherwise mem_read=1, mem_write=0.
  - Command type is sampled at grant.
- Response, in a SERVE state with mem_resp=1:
  - Drive the granted requester's resp high combinationally in the same cycle; the other resp stays 0.
  - Drop mem_read/mem_write at the next edge.
  - Update last_grant to the served requester and go to RELEASE.
- i_rdata and d_rdata continuously equal mem_rdata. Requesters may only use the data when their resp is high.
- RELEASE:
  - Lasts exactly one cycle with no grant, so the requester can drop its request.
  - Then IDLE.
  - Minimum request-to-request spacing per requester: grant cycle + 1 + downstream latency + RELEASE.
- Watchdog:
  - Counter clears on grant and increments each SERVE cycle without mem_resp; it saturates.
  - When the count reaches MAX_WAIT, timeout_err sets and stays set until reset.
  - The transaction keeps waiting; it is not aborted.
- Requests that drop before grant are not served. Requests that drop mid-SERVE are illegal and not checked.

Decomposition:
- Add to the lc3b_types package:
  - enum lc3b_arb_state {IDLE, SERVE_I, SERVE_D, RELEASE}.
  - enum lc3b_arb_req {ARB_ICACHE, ARB_DCACHE}.
  - Line-align mask constant (low 4 bits cleared).
- Reuse lc3b_word and lc3b_cache_line for all address and data ports.
- No sub-module required; the watchdog counter is inline. arb_wait_counter is the only natural split if one is wanted.

Test Plan:
- I-cache read only, i_address=0x1234:
  - Next cycle mem_read=1 and mem_address=0x1230.
  - Drive mem_resp on the 3rd cycle with mem_rdata=0x0123...CDEF. Same cycle: i_resp=1, i_rdata matches, d_resp=0.
  - Next cycle: mem_read=0, busy=1 (RELEASE). Then busy=0.
- D-cache write, d_address=0xABCD, d_wdata=0xFFFF...0000:
  - mem_write=1, mem_read=0, mem_address=0xABC0, mem_wdata matches.
  - d_resp pulses for exactly one cycle with mem_resp.
- After reset, i_read and d_read asserted together: D-cache granted first. After RELEASE, I-cache granted.
- Both requesters re-request continuously: grant order D, I, D, I. No requester ever gets two consecutive grants while the other is pending.
- MAX_WAIT=255, mem_resp withheld: timeout_err rises after 255 SERVE cycles and mem_read remains 1. A late mem_resp completes normally and timeout_err stays 1.
- rst_n=0 during SERVE_D with mem_write=1:
  - Next edge: all outputs 0 and IDLE.
  - A mem_resp pulse after reset yields no i_resp or d_resp.
